// File: rtl/laser_beam_tx_if.sv
// laser_beam_tx_if: enable/detector inputs and emitter/status outputs
// of the laser gate transmitter. master = transmitter, slave = user.
interface laser_beam_tx_if;
    logic       en;
    logic       laser_detector;
    logic       laser_drive;
    logic       frame_ok;
    logic       beam_broken;
    logic       break_pulse;
    logic [3:0] miss_count;

    modport master (
        input  en,
        input  laser_detector,
        output laser_drive,
        output frame_ok,
        output beam_broken,
        output break_pulse,
        output miss_count
    );

    modport slave (
        output en,
        output laser_detector,
        input  laser_drive,
        input  frame_ok,
        input  beam_broken,
        input  break_pulse,
        input  miss_count
    );
endinterface

// File: rtl/laser_beam_tx.sv
// laser_beam_tx: framed carrier emitter with synchronous detection.
// Ports: master_clk, rs_n (async active-low), bus (laser_beam_tx_if.master).
module laser_beam_tx #(
    parameter int CARRIER_DIV  = 1250,
    parameter int BURST_CYCLES = 8,
    parameter int GAP_CYCLES   = 8,
    parameter int HIT_MIN      = 6,
    parameter int AMB_MAX      = 2,
    parameter int MISS_LIMIT   = 3
) (
    input  logic               master_clk,
    input  logic               rs_n,
    laser_beam_tx_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        GAP,
        EVAL
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CARRIER_DIV - 1);
    localparam logic [15:0] DIV_MID  = 16'(CARRIER_DIV / 2);
    localparam logic [7:0]  B_LAST   = 8'(2 * BURST_CYCLES - 1);
    localparam logic [7:0]  G_LAST   = 8'(2 * GAP_CYCLES - 1);
    localparam logic [7:0]  HIT_TH   = 8'(HIT_MIN);
    localparam logic [7:0]  AMB_TH   = 8'(AMB_MAX);
    localparam logic [3:0]  MISS_LIM = 4'(MISS_LIMIT);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] div_cnt;
    logic [7:0]  half_cnt;
    logic [7:0]  hit_cnt;
    logic [7:0]  amb_cnt;
    logic        drive;
    logic        det_m;
    logic        det_s;
    logic        ok_q;
    logic        brk_q;
    logic        broken_q;
    logic [3:0]  miss_q;

    logic        wrap;
    logic        mid;
    logic        to_eval;
    logic        good;
    logic [3:0]  miss_inc;
    logic        running;

    assign wrap     = (div_cnt == DIV_LAST);
    assign mid      = (div_cnt == DIV_MID);
    assign good     = (hit_cnt >= HIT_TH) && (amb_cnt <= AMB_TH);
    assign miss_inc = (miss_q == MISS_LIM) ? miss_q : miss_q + 4'd1;
    assign running  = (state == BURST) || (state == GAP);

    always_ff @(posedge master_clk or negedge rs_n) begin
        if (!rs_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        to_eval   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.en) state_nxt = BURST;
            end
            BURST: begin
                if (!bus.en)
                    state_nxt = IDLE;
                else if (wrap && half_cnt == B_LAST)
                    state_nxt = GAP;
            end
            GAP: begin
                if (!bus.en) begin
                    state_nxt = IDLE;
                end else if (wrap && half_cnt == G_LAST) begin
                    state_nxt = EVAL;
                    to_eval   = 1'b1;
                end
            end
            EVAL: begin
                state_nxt = bus.en ? BURST : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame verdict is registered on entry to EVAL, so the pulses and
    // the updated miss/broken levels all appear in the EVAL cycle.
    always_ff @(posedge master_clk or negedge rs_n) begin
        if (!rs_n) begin
            div_cnt  <= '0;
            half_cnt <= '0;
            hit_cnt  <= '0;
            amb_cnt  <= '0;
            drive    <= 1'b0;
            det_m    <= 1'b0;
            det_s    <= 1'b0;
            ok_q     <= 1'b0;
            brk_q    <= 1'b0;
            broken_q <= 1'b0;
            miss_q   <= '0;
        end else begin
            det_m <= bus.laser_detector;
            det_s <= det_m;
            ok_q  <= 1'b0;
            brk_q <= 1'b0;
            if (state_nxt == IDLE) begin
                div_cnt  <= '0;
                half_cnt <= '0;
                hit_cnt  <= '0;
                amb_cnt  <= '0;
                drive    <= 1'b0;
            end else if (!running) begin
                div_cnt  <= '0;
                half_cnt <= '0;
                hit_cnt  <= '0;
                amb_cnt  <= '0;
                drive    <= 1'b1;
            end else begin
                div_cnt <= wrap ? '0 : div_cnt + 16'd1;
                if (wrap)
                    half_cnt <= (state_nxt != state) ? '0
                                : half_cnt + 8'd1;
                if (state_nxt == BURST)
                    drive <= wrap ? ~drive : drive;
                else
                    drive <= 1'b0;
                if (state == BURST && mid && drive && det_s
                    && hit_cnt != 8'hFF)
                    hit_cnt <= hit_cnt + 8'd1;
                if (state == GAP && mid && det_s
                    && amb_cnt != 8'hFF)
                    amb_cnt <= amb_cnt + 8'd1;
            end
            if (to_eval) begin
                if (good) begin
                    ok_q     <= 1'b1;
                    miss_q   <= '0;
                    broken_q <= 1'b0;
                end else begin
                    miss_q <= miss_inc;
                    if (miss_inc == MISS_LIM && !broken_q) begin
                        broken_q <= 1'b1;
                        brk_q    <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.laser_drive = drive;
    assign bus.frame_ok    = ok_q;
    assign bus.break_pulse = brk_q;
    assign bus.beam_broken = broken_q;
    assign bus.miss_count  = miss_q;

endmodule

// File: tb/tb_laser_beam_tx.sv
// tb_laser_beam_tx: frame-level reference model of the laser gate,
// directed scenarios plus randomized per-half detector patterns.
module tb_laser_beam_tx;

    localparam int DIV   = 8;
    localparam int BC    = 4;
    localparam int GC    = 4;
    localparam int HMIN  = 3;
    localparam int AMAX  = 1;
    localparam int MLIM  = 3;
    localparam int NH    = 2 * (BC + GC);
    localparam int FRAME = NH * DIV + 1;

    localparam int M_LOOP = 0;
    localparam int M_DARK = 1;
    localparam int M_LIT  = 2;
    localparam int M_RAND = 3;

    logic master_clk = 1'b0;
    logic rs_n = 1'b0;

    laser_beam_tx_if bus();

    laser_beam_tx #(
        .CARRIER_DIV (DIV),
        .BURST_CYCLES(BC),
        .GAP_CYCLES  (GC),
        .HIT_MIN     (HMIN),
        .AMB_MAX     (AMAX),
        .MISS_LIMIT  (MLIM)
    ) dut (
        .master_clk(master_clk),
        .rs_n      (rs_n),
        .bus       (bus)
    );

    always #5 master_clk = ~master_clk;

    int ncmp = 0;
    int nfail = 0;
    int exp_miss = 0;
    bit exp_broken = 1'b0;
    bit lit[NH];

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input bit ed,
                           input bit ef, input bit eb);
        chk({tag, ".drive"}, 8'(bus.laser_drive), 8'(ed));
        chk({tag, ".frame_ok"}, 8'(bus.frame_ok), 8'(ef));
        chk({tag, ".break_pulse"}, 8'(bus.break_pulse), 8'(eb));
        chk({tag, ".miss"}, 8'(bus.miss_count), 8'(exp_miss));
        chk({tag, ".broken"}, 8'(bus.beam_broken), 8'(exp_broken));
    endtask

    // Detector level held for each half-period of the frame.
    task automatic set_lit(input int mode);
        for (int h = 0; h < NH; h++) begin
            case (mode)
                M_LOOP: lit[h] = (h < 2 * BC) && (h % 2 == 0);
                M_DARK: lit[h] = 1'b0;
                M_LIT:  lit[h] = 1'b1;
                default: begin
                    if (h < 2 * BC && h % 2 == 0)
                        lit[h] = ($urandom_range(0, 3) != 0);
                    else if (h < 2 * BC)
                        lit[h] = 1'($urandom_range(0, 1));
                    else
                        lit[h] = ($urandom_range(0, 7) == 0);
                end
            endcase
        end
    endtask

    // Entered one unit after the edge that starts a frame (k=0).
    // At k==stop_at en is dropped before the following edge.
    task automatic run_frame(input string tag, input int mode,
                             input int stop_at);
        int hits;
        int amb;
        bit ed;
        bit ef;
        bit eb;
        set_lit(mode);
        for (int k = 0; k < FRAME; k++) begin
            ed = (k < 2 * BC * DIV) && ((k / DIV) % 2 == 0);
            ef = 1'b0;
            eb = 1'b0;
            if (k == FRAME - 1) begin
                hits = 0;
                amb = 0;
                for (int h = 0; h < NH; h++) begin
                    if (h < 2 * BC && h % 2 == 0 && lit[h]) hits++;
                    if (h >= 2 * BC && lit[h]) amb++;
                end
                if (hits >= HMIN && amb <= AMAX) begin
                    ef = 1'b1;
                    exp_miss = 0;
                    exp_broken = 1'b0;
                end else begin
                    if (exp_miss < MLIM) exp_miss++;
                    if (exp_miss == MLIM && !exp_broken) begin
                        exp_broken = 1'b1;
                        eb = 1'b1;
                    end
                end
            end
            chk_all(tag, ed, ef, eb);
            if (k >= 1) bus.laser_detector = lit[(k - 1) / DIV];
            if (k == stop_at) begin
                bus.en = 1'b0;
                break;
            end
            @(posedge master_clk);
            #1;
        end
        if (stop_at < FRAME) begin
            @(posedge master_clk);
            #1;
        end
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk_all(tag, 1'b0, 1'b0, 1'b0);
            @(posedge master_clk);
            #1;
        end
    endtask

    task automatic start_tx();
        bus.en = 1'b1;
        @(posedge master_clk);
        #1;
    endtask

    initial begin
        bus.en = 1'b0;
        bus.laser_detector = 1'b0;
        #2;
        chk_all("reset", 1'b0, 1'b0, 1'b0);
        @(negedge master_clk);
        rs_n = 1'b1;
        @(posedge master_clk);
        #1;
        idle_cycles("idle0", 5);

        start_tx();
        run_frame("loop1", M_LOOP, FRAME);
        run_frame("loop2", M_LOOP, FRAME);

        run_frame("dark1", M_DARK, FRAME);
        run_frame("dark2", M_DARK, FRAME);
        run_frame("dark3", M_DARK, FRAME);
        run_frame("dark4", M_DARK, FRAME);

        run_frame("recover", M_LOOP, FRAME);

        run_frame("amb1", M_LIT, FRAME);
        run_frame("amb2", M_LIT, FRAME);
        run_frame("amb3", M_LIT, FRAME);

        @(posedge master_clk);
        #1;
        chk("pre_rst.drive", 8'(bus.laser_drive), 8'd1);
        #1;
        rs_n = 1'b0;
        #1;
        exp_miss = 0;
        exp_broken = 1'b0;
        chk_all("async_rst", 1'b0, 1'b0, 1'b0);
        #1;
        rs_n = 1'b1;
        @(posedge master_clk);
        #1;
        run_frame("post_rst", M_LOOP, FRAME);

        run_frame("m_a", M_DARK, FRAME);
        run_frame("m_b", M_DARK, FRAME);
        run_frame("gap_drop", M_DARK, 100);
        idle_cycles("held", 150);
        start_tx();
        run_frame("one_bad", M_DARK, FRAME - 1);
        idle_cycles("idle1", 10);

        start_tx();
        for (int i = 0; i < 10; i++)
            run_frame("rand", M_RAND, (i == 9) ? FRAME - 1 : FRAME);
        idle_cycles("idle2", 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
